// File: rtl/clk_meter_pkg.sv
// Shared definitions for the clock period meter: FSM state encoding and
// the default abort limit for waiting on an edge.
package clk_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 1000;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level input, followed by a
// history flop that yields single-cycle rise/fall strobes.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Strobes come only from fully synchronized samples.
    assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures sig_in period (and, with CLK_METER_DUTY_EN defined, its high time)
// in clk cycles between consecutive rising edges; aborts after TIMEOUT cycles.
module clock_period_meter
    import clk_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             rise_det, fall_det;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .d_i   (sig_in),
        .rise_o(rise_det),
        .fall_o(fall_det)
    );

`ifdef CLK_METER_DUTY_EN
    logic [CNT_W-1:0] hi_shadow_q, hi_shadow_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
`else
    logic fall_unused;
    assign fall_unused = fall_det;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
`ifdef CLK_METER_DUTY_EN
        hi_shadow_d = hi_shadow_q;
        high_time_d = high_time_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARM;
                    cnt_d   = '0;
                end
            end
            ARM: begin
                if (rise_det) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_ONE;
`ifdef CLK_METER_DUTY_EN
                    hi_shadow_d = '0;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            MEASURE: begin
                // An edge arriving on the last allowed cycle still completes the period.
                if (rise_det) begin
                    period_d = cnt_q;
                    valid_d  = 1'b1;
`ifdef CLK_METER_DUTY_EN
                    high_time_d = hi_shadow_q;
                    hi_shadow_d = '0;
`endif
                    if (cont) begin
                        cnt_d = CNT_ONE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
`ifdef CLK_METER_DUTY_EN
                    if (fall_det) begin
                        hi_shadow_d = cnt_q;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
`ifdef CLK_METER_DUTY_EN
            hi_shadow_q <= '0;
            high_time_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
`ifdef CLK_METER_DUTY_EN
            hi_shadow_q <= hi_shadow_d;
            high_time_q <= high_time_d;
`endif
        end
    end

    assign period  = period_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;
    assign busy    = (state_q != IDLE);
`ifdef CLK_METER_DUTY_EN
    assign high_time = high_time_q;
`else
    assign high_time = '0;
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed, table-driven bench for clock_period_meter with a cycle-aligned
// sig_in pattern generator.
module tb_clock_period_meter;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 50;
    localparam int SYNC    = 3;
`ifdef CLK_METER_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             sig_in = 1'b0;
    logic             start  = 1'b0;
    logic             cont   = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             timeout;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    int gen_p  = 10;
    int gen_h  = 5;
    bit gen_en = 1'b0;
    int ph     = 0;

    clock_period_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig_in),
        .start    (start),
        .cont     (cont),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .timeout  (timeout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Periodic sig_in: rises when ph wraps to 0, high for gen_h cycles.
    always begin
        @(posedge clk);
        #1;
        if (gen_en) begin
            ph     = (ph + 1 >= gen_p) ? 0 : ph + 1;
            sig_in = (ph < gen_h);
        end else begin
            ph     = 0;
            sig_in = 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic align_phase();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (ph != 0 && n < 200);
    endtask

    // Pulses start, then watches outputs until busy drops or the budget expires.
    task automatic measure(input int nv_exp, input int restart_at,
                           input logic [31:0] exp_per, input logic [31:0] exp_hi,
                           output int nv, output int nto, output int to_cyc,
                           output int first_v, output int val_err);
        int  last;
        bit  done;
        last = -1; done = 1'b0;
        nv = 0; nto = 0; to_cyc = -1; first_v = -1; val_err = 0;
        if (nv_exp <= 1) cont = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 600; i++) begin
            @(posedge clk);
            #1;
            start = (i == restart_at);
            if (valid) begin
                nv++;
                if (first_v < 0) first_v = i;
                if (period !== exp_per || high_time !== exp_hi) val_err++;
                if (last >= 0 && i - last != gen_p) val_err++;
                last = i;
                if (nv >= nv_exp - 1) cont = 1'b0;
            end
            if (timeout) begin
                nto++;
                to_cyc = i;
            end
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL measure_budget: busy still %0d after 600 cycles, required 0", busy);
        end
    endtask

    typedef struct {
        int          p;
        int          h;
        bit          c;
        int          nv;
        int          nto;
        logic [31:0] per;
        logic [31:0] hi;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int nv, nto, to_cyc, first_v, val_err, saw_valid;
        logic [31:0] ehi;

        vecs[0] = '{p: 10, h: 5,  c: 1'b0, nv: 1, nto: 0, per: 10, hi: 5};
        vecs[1] = '{p: 37, h: 12, c: 1'b1, nv: 3, nto: 0, per: 37, hi: 12};
        vecs[2] = '{p: 20, h: 1,  c: 1'b0, nv: 1, nto: 0, per: 20, hi: 1};
        // Edge lands on the last allowed count: edge wins over abort.
        vecs[3] = '{p: 49, h: 48, c: 1'b0, nv: 1, nto: 0, per: 49, hi: 48};
        // One cycle too long: abort, previous result retained.
        vecs[4] = '{p: 50, h: 20, c: 1'b0, nv: 0, nto: 1, per: 49, hi: 48};
        vecs[5] = '{p: 3,  h: 1,  c: 1'b0, nv: 1, nto: 0, per: 3,  hi: 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_period", period, 0);
        check("rst_high_time", high_time, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // sig_in stuck low: abort exactly TIMEOUT cycles after start is taken
        gen_en = 1'b0;
        measure(1, -1, 0, 0, nv, nto, to_cyc, first_v, val_err);
        check("stuck_valid_count", nv, 0);
        check("stuck_timeout_count", nto, 1);
        check("stuck_timeout_cycle", to_cyc, TIMEOUT);
        check("stuck_period", period, 0);

        foreach (vecs[k]) begin
            ehi    = DUTY ? vecs[k].hi : 32'd0;
            gen_p  = vecs[k].p;
            gen_h  = vecs[k].h;
            gen_en = 1'b1;
            repeat (110) @(posedge clk);
            #1;
            cont = vecs[k].c;
            measure(vecs[k].nv, -1, vecs[k].per, ehi, nv, nto, to_cyc, first_v, val_err);
            check($sformatf("v%0d_valid_count", k), nv, vecs[k].nv);
            check($sformatf("v%0d_timeout_count", k), nto, vecs[k].nto);
            check($sformatf("v%0d_each_result", k), val_err, 0);
            check($sformatf("v%0d_period", k), period, vecs[k].per);
            check($sformatf("v%0d_high_time", k), high_time, ehi);
            check($sformatf("v%0d_busy", k), busy, 0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pulse_width", k), {valid, timeout}, 2'b00);
        end
        cont = 1'b0;

        // Reset about 20 cycles into MEASURE
        gen_p = 37; gen_h = 12;
        repeat (80) @(posedge clk);
        align_phase();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        saw_valid = 0;
        repeat (24) begin
            @(posedge clk);
            #1;
            if (valid) saw_valid++;
        end
        rst = 1'b1;
        #1;
        check("midrst_period", period, 0);
        check("midrst_high_time", high_time, 0);
        check("midrst_busy", busy, 0);
        check("midrst_valid_timeout", {valid, timeout}, 2'b00);
        repeat (3) begin
            @(posedge clk);
            #1;
            if (valid) saw_valid++;
        end
        rst = 1'b0;
        check("midrst_no_valid", saw_valid, 0);
        repeat (5) @(posedge clk);
        #1;
        measure(1, -1, 37, DUTY ? 32'd12 : 32'd0, nv, nto, to_cyc, first_v, val_err);
        check("postrst_valid_count", nv, 1);
        check("postrst_period", period, 37);
        check("postrst_high_time", high_time, DUTY ? 64'd12 : 64'd0);

        // start pulsed during MEASURE is ignored; valid lands at SYNC+P cycles
        gen_p = 20; gen_h = 7;
        repeat (60) @(posedge clk);
        align_phase();
        measure(1, 12, 20, DUTY ? 32'd7 : 32'd0, nv, nto, to_cyc, first_v, val_err);
        check("restart_valid_count", nv, 1);
        check("restart_valid_cycle", first_v, SYNC + 20);
        check("restart_period", period, 20);
        check("restart_high_time", high_time, DUTY ? 64'd7 : 64'd0);
        check("restart_timeout_count", nto, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
